// File: rtl/spi_slave_axi_bridge_if.sv
`default_nettype none
// ============================================================================
//  Module      : spi_slave_axi_bridge_if
//  Description : AXI4 bundle between the SPI slave bridge (master modport)
//                and the SoC interconnect (slave modport). Carries the
//                AW, W, B, AR and R channels with their standard fields.
//  Ports       : none; the signal set is sized by the four width parameters.
//  Revision    : 1.0 - initial release
// ============================================================================
interface spi_slave_axi_bridge_if #(
   parameter int AXI_ADDR_WIDTH = 32,
   parameter int AXI_DATA_WIDTH = 64,
   parameter int AXI_USER_WIDTH = 6,
   parameter int AXI_ID_WIDTH   = 3
) ();
   // write address channel
   logic                        aw_valid;
   logic                        aw_ready;
   logic [AXI_ADDR_WIDTH-1:0]   aw_addr;
   logic [7:0]                  aw_len;
   logic [2:0]                  aw_size;
   logic [1:0]                  aw_burst;
   logic [AXI_ID_WIDTH-1:0]     aw_id;
   logic [2:0]                  aw_prot;
   logic [3:0]                  aw_region;
   logic                        aw_lock;
   logic [3:0]                  aw_cache;
   logic [3:0]                  aw_qos;
   logic [AXI_USER_WIDTH-1:0]   aw_user;
   // write data channel
   logic                        w_valid;
   logic                        w_ready;
   logic [AXI_DATA_WIDTH-1:0]   w_data;
   logic [AXI_DATA_WIDTH/8-1:0] w_strb;
   logic                        w_last;
   logic [AXI_USER_WIDTH-1:0]   w_user;
   // write response channel
   logic                        b_valid;
   logic                        b_ready;
   logic [1:0]                  b_resp;
   logic [AXI_ID_WIDTH-1:0]     b_id;
   logic [AXI_USER_WIDTH-1:0]   b_user;
   // read address channel
   logic                        ar_valid;
   logic                        ar_ready;
   logic [AXI_ADDR_WIDTH-1:0]   ar_addr;
   logic [7:0]                  ar_len;
   logic [2:0]                  ar_size;
   logic [1:0]                  ar_burst;
   logic [AXI_ID_WIDTH-1:0]     ar_id;
   logic [2:0]                  ar_prot;
   logic [3:0]                  ar_region;
   logic                        ar_lock;
   logic [3:0]                  ar_cache;
   logic [3:0]                  ar_qos;
   logic [AXI_USER_WIDTH-1:0]   ar_user;
   // read data channel
   logic                        r_valid;
   logic                        r_ready;
   logic [AXI_DATA_WIDTH-1:0]   r_data;
   logic [1:0]                  r_resp;
   logic                        r_last;
   logic [AXI_ID_WIDTH-1:0]     r_id;
   logic [AXI_USER_WIDTH-1:0]   r_user;

   modport master (
      output aw_valid, aw_addr, aw_len, aw_size, aw_burst, aw_id, aw_prot,
             aw_region, aw_lock, aw_cache, aw_qos, aw_user,
      input  aw_ready,
      output w_valid, w_data, w_strb, w_last, w_user,
      input  w_ready,
      input  b_valid, b_resp, b_id, b_user,
      output b_ready,
      output ar_valid, ar_addr, ar_len, ar_size, ar_burst, ar_id, ar_prot,
             ar_region, ar_lock, ar_cache, ar_qos, ar_user,
      input  ar_ready,
      input  r_valid, r_data, r_resp, r_last, r_id, r_user,
      output r_ready
   );

   modport slave (
      input  aw_valid, aw_addr, aw_len, aw_size, aw_burst, aw_id, aw_prot,
             aw_region, aw_lock, aw_cache, aw_qos, aw_user,
      output aw_ready,
      input  w_valid, w_data, w_strb, w_last, w_user,
      output w_ready,
      output b_valid, b_resp, b_id, b_user,
      input  b_ready,
      input  ar_valid, ar_addr, ar_len, ar_size, ar_burst, ar_id, ar_prot,
             ar_region, ar_lock, ar_cache, ar_qos, ar_user,
      output ar_ready,
      output r_valid, r_data, r_resp, r_last, r_id, r_user,
      input  r_ready
   );
endinterface
`default_nettype wire

// File: rtl/spi_slave_axi_bridge.sv
`default_nettype none
// ============================================================================
//  Module      : spi_slave_axi_bridge
//  Description : AXI4 master between the SPI slave word FIFOs and the SoC
//                interconnect. Every received SPI word becomes one single-beat
//                AXI write; SPI reads fetch bus-width beats and stream them out
//                as 32-bit words. Separate auto-incrementing read/write
//                pointers, AXI-legal abort on chip-select, sticky errors.
//  Ports       : axi_aclk / axi_aresetn     clock, async active-low reset
//                m_axi                      AXI4 master bundle
//                i_rxtx_addr(_valid)        start address load strobe
//                i_start_tx, i_cs           read streaming start, chip select
//                i_rx_data/valid, o_rx_ready   write words from SPI RX FIFO
//                o_tx_data/valid, i_tx_ready   read words to SPI TX FIFO
//                o_wr_err, o_rd_err, i_err_clr sticky error flags and clear
//  Revision    : 1.0 - initial release
// ============================================================================
module spi_slave_axi_bridge #(
   parameter int AXI_ADDR_WIDTH = 32,
   parameter int AXI_DATA_WIDTH = 64,
   parameter int AXI_USER_WIDTH = 6,
   parameter int AXI_ID_WIDTH   = 3,
   parameter int AXI_ID         = 1
) (
   input  logic                         axi_aclk,
   input  logic                         axi_aresetn,
   spi_slave_axi_bridge_if.master       m_axi,
   input  logic [31:0]                  i_rxtx_addr,
   input  logic                         i_rxtx_addr_valid,
   input  logic                         i_start_tx,
   input  logic                         i_cs,
   input  logic [31:0]                  i_rx_data,
   input  logic                         i_rx_valid,
   output logic                         o_rx_ready,
   output logic [31:0]                  o_tx_data,
   output logic                         o_tx_valid,
   input  logic                         i_tx_ready,
   output logic                         o_wr_err,
   output logic                         o_rd_err,
   input  logic                         i_err_clr
);
   localparam int          c_LANES = AXI_DATA_WIDTH / 32;
   localparam int          c_SW    = AXI_DATA_WIDTH / 8;
   localparam int          c_OFS   = $clog2(c_SW);
   localparam int          c_LW    = (c_LANES > 1) ? $clog2(c_LANES) : 1;
   localparam logic [31:0] c_AMASK = ~(32'(c_SW - 1));

   typedef enum logic [1:0] {W_IDLE, W_REQ, W_RESP} wstate_t;
   typedef enum logic [2:0] {R_IDLE, R_ADDR, R_DATA, R_SEND, R_DRAIN} rstate_t;

   wstate_t                   r_wstate, w_wstate_nxt;
   rstate_t                   r_rstate, w_rstate_nxt;
   logic [31:0]               r_waddr, r_raddr, r_wdata;
   logic [AXI_DATA_WIDTH-1:0] r_rbeat;
   logic                      r_aw_done, r_w_done, r_run, r_abort;
   logic                      r_wr_err, r_rd_err;

   logic                      w_aw_valid, w_w_valid, w_b_ready;
   logic                      w_ar_valid, w_r_ready;
   logic                      w_winc, w_rinc, w_beat_cap;
   logic                      w_wr_err_set, w_rd_err_set;
   logic                      w_abort;
   logic [c_LW-1:0]           w_wlane, w_rlane;
   logic [c_LANES-1:0][31:0]  w_rlanes;
   logic [AXI_ADDR_WIDTH-1:0] w_aw_addr, w_ar_addr;

   // Lane of the 32-bit word inside the bus beat; a 32-bit bus has only lane 0.
   generate
      if (c_LANES > 1) begin : g_multi_lane
         assign w_wlane = r_waddr[c_OFS-1:2];
         assign w_rlane = r_raddr[c_OFS-1:2];
      end else begin : g_single_lane
         assign w_wlane = 1'b0;
         assign w_rlane = 1'b0;
      end
   endgenerate

   assign w_rlanes = r_rbeat;
   // Abort is remembered so a cs glitch during an outstanding read still drains.
   assign w_abort  = i_cs | r_abort;

   // ------------------------------------------------------------------ write
   always_comb begin
      w_wstate_nxt = r_wstate;
      o_rx_ready   = 1'b0;
      w_aw_valid   = 1'b0;
      w_w_valid    = 1'b0;
      w_b_ready    = 1'b0;
      w_winc       = 1'b0;
      w_wr_err_set = 1'b0;
      case (r_wstate)
         W_IDLE: begin
            // r_run keeps rx_ready low while reset is held
            o_rx_ready = r_run;
            if (r_run && i_rx_valid) w_wstate_nxt = W_REQ;
         end
         W_REQ: begin
            w_aw_valid = !r_aw_done;
            w_w_valid  = !r_w_done;
            if ((r_aw_done || m_axi.aw_ready) && (r_w_done || m_axi.w_ready))
               w_wstate_nxt = W_RESP;
         end
         W_RESP: begin
            w_b_ready = 1'b1;
            if (m_axi.b_valid) begin
               w_winc       = 1'b1;
               w_wr_err_set = (m_axi.b_resp != 2'b00);
               w_wstate_nxt = W_IDLE;
            end
         end
         default: w_wstate_nxt = W_IDLE;
      endcase
   end

   always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
      if (!axi_aresetn) begin
         r_wstate  <= W_IDLE;
         r_wdata   <= '0;
         r_aw_done <= 1'b0;
         r_w_done  <= 1'b0;
         r_run     <= 1'b0;
      end else begin
         r_run    <= 1'b1;
         r_wstate <= w_wstate_nxt;
         if (o_rx_ready && i_rx_valid) begin
            r_wdata   <= i_rx_data;
            r_aw_done <= 1'b0;
            r_w_done  <= 1'b0;
         end else begin
            if (w_aw_valid && m_axi.aw_ready) r_aw_done <= 1'b1;
            if (w_w_valid && m_axi.w_ready)   r_w_done  <= 1'b1;
         end
      end
   end

   // ------------------------------------------------------------------- read
   always_comb begin
      w_rstate_nxt = r_rstate;
      w_ar_valid   = 1'b0;
      w_r_ready    = 1'b0;
      o_tx_valid   = 1'b0;
      w_rinc       = 1'b0;
      w_beat_cap   = 1'b0;
      w_rd_err_set = 1'b0;
      case (r_rstate)
         R_IDLE: begin
            if (i_start_tx && !i_cs) w_rstate_nxt = R_ADDR;
         end
         R_ADDR: begin
            // AR must stay valid until accepted, even when aborting
            w_ar_valid = 1'b1;
            if (m_axi.ar_ready) w_rstate_nxt = w_abort ? R_DRAIN : R_DATA;
         end
         R_DATA: begin
            w_r_ready = 1'b1;
            if (m_axi.r_valid) begin
               w_beat_cap   = 1'b1;
               w_rd_err_set = (m_axi.r_resp != 2'b00);
               w_rstate_nxt = w_abort ? R_IDLE : R_SEND;
            end else if (w_abort) begin
               w_rstate_nxt = R_DRAIN;
            end
         end
         R_SEND: begin
            // tx_valid is masked by cs so no word leaves once cs has risen
            if (w_abort) begin
               w_rstate_nxt = R_IDLE;
            end else begin
               o_tx_valid = 1'b1;
               if (i_tx_ready) begin
                  w_rinc = 1'b1;
                  if (w_rlane == c_LW'(c_LANES - 1)) w_rstate_nxt = R_ADDR;
               end
            end
         end
         R_DRAIN: begin
            w_r_ready = 1'b1;
            if (m_axi.r_valid) w_rstate_nxt = R_IDLE;
         end
         default: w_rstate_nxt = R_IDLE;
      endcase
   end

   always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
      if (!axi_aresetn) begin
         r_rstate <= R_IDLE;
         r_rbeat  <= '0;
         r_abort  <= 1'b0;
      end else begin
         r_rstate <= w_rstate_nxt;
         if (w_beat_cap) r_rbeat <= m_axi.r_data;
         if (r_rstate == R_IDLE) r_abort <= 1'b0;
         else if (i_cs)          r_abort <= 1'b1;
      end
   end

   // ------------------------------------------------ address pointers, errors
   always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
      if (!axi_aresetn) begin
         r_waddr  <= '0;
         r_raddr  <= '0;
         r_wr_err <= 1'b0;
         r_rd_err <= 1'b0;
      end else begin
         // a load beats any same-cycle increment; +4 wraps naturally at 2^32
         if (i_rxtx_addr_valid) begin
            r_waddr <= i_rxtx_addr;
            r_raddr <= i_rxtx_addr;
         end else begin
            if (w_winc) r_waddr <= r_waddr + 32'd4;
            if (w_rinc) r_raddr <= r_raddr + 32'd4;
         end
         if (w_wr_err_set)   r_wr_err <= 1'b1;
         else if (i_err_clr) r_wr_err <= 1'b0;
         if (w_rd_err_set)   r_rd_err <= 1'b1;
         else if (i_err_clr) r_rd_err <= 1'b0;
      end
   end

   always_comb begin
      w_aw_addr        = '0;
      w_aw_addr[31:0]  = r_waddr;
      w_ar_addr        = '0;
      w_ar_addr[31:0]  = r_raddr & c_AMASK;
   end

   // --------------------------------------------------------------- outputs
   assign o_tx_data = w_rlanes[w_rlane];
   assign o_wr_err  = r_wr_err;
   assign o_rd_err  = r_rd_err;

   assign m_axi.aw_valid  = w_aw_valid;
   assign m_axi.aw_addr   = w_aw_addr;
   assign m_axi.aw_len    = 8'd0;
   assign m_axi.aw_size   = 3'b010;
   assign m_axi.aw_burst  = 2'b01;
   assign m_axi.aw_id     = AXI_ID_WIDTH'(AXI_ID);
   assign m_axi.aw_prot   = 3'b000;
   assign m_axi.aw_region = 4'h0;
   assign m_axi.aw_lock   = 1'b0;
   assign m_axi.aw_cache  = 4'h0;
   assign m_axi.aw_qos    = 4'h0;
   assign m_axi.aw_user   = '0;

   assign m_axi.w_valid   = w_w_valid;
   assign m_axi.w_data    = {c_LANES{r_wdata}};
   assign m_axi.w_strb    = c_SW'(4'hF) << {w_wlane, 2'b00};
   assign m_axi.w_last    = 1'b1;
   assign m_axi.w_user    = '0;
   assign m_axi.b_ready   = w_b_ready;

   assign m_axi.ar_valid  = w_ar_valid;
   assign m_axi.ar_addr   = w_ar_addr;
   assign m_axi.ar_len    = 8'd0;
   assign m_axi.ar_size   = 3'(c_OFS);
   assign m_axi.ar_burst  = 2'b01;
   assign m_axi.ar_id     = AXI_ID_WIDTH'(AXI_ID);
   assign m_axi.ar_prot   = 3'b000;
   assign m_axi.ar_region = 4'h0;
   assign m_axi.ar_lock   = 1'b0;
   assign m_axi.ar_cache  = 4'h0;
   assign m_axi.ar_qos    = 4'h0;
   assign m_axi.ar_user   = '0;
   assign m_axi.r_ready   = w_r_ready;

   // response id/user/last carry nothing this single-beat master needs
   logic w_unused;
   assign w_unused = ^{m_axi.b_id, m_axi.b_user, m_axi.r_last, m_axi.r_id, m_axi.r_user};
endmodule
`default_nettype wire

// File: tb/tb_spi_slave_axi_bridge.sv
`default_nettype none
// ============================================================================
//  Module      : tb_spi_slave_axi_bridge
//  Description : Self-checking bench. A 64-bit instance exercises the write
//                path from a table of vectors; a 128-bit instance exercises
//                read streaming, cs aborts and the read error flag.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_spi_slave_axi_bridge;
   logic axi_aclk = 1'b0;
   logic axi_aresetn;
   always #5 axi_aclk = ~axi_aclk;

   int n_checks = 0;
   int n_errors = 0;

   spi_slave_axi_bridge_if #(.AXI_ADDR_WIDTH(32), .AXI_DATA_WIDTH(64),
                             .AXI_USER_WIDTH(6), .AXI_ID_WIDTH(3)) axi64 ();
   spi_slave_axi_bridge_if #(.AXI_ADDR_WIDTH(32), .AXI_DATA_WIDTH(128),
                             .AXI_USER_WIDTH(6), .AXI_ID_WIDTH(3)) axi128 ();

   logic [31:0] d64_addr, d64_rx_data, d64_tx_data;
   logic        d64_addr_v, d64_start, d64_cs, d64_rx_valid, d64_rx_ready;
   logic        d64_tx_valid, d64_tx_ready, d64_wr_err, d64_rd_err, d64_err_clr;
   logic [31:0] d128_addr, d128_rx_data, d128_tx_data;
   logic        d128_addr_v, d128_start, d128_cs, d128_rx_valid, d128_rx_ready;
   logic        d128_tx_valid, d128_tx_ready, d128_wr_err, d128_rd_err, d128_err_clr;

   spi_slave_axi_bridge #(.AXI_DATA_WIDTH(64)) dut64 (
      .axi_aclk(axi_aclk), .axi_aresetn(axi_aresetn), .m_axi(axi64.master),
      .i_rxtx_addr(d64_addr), .i_rxtx_addr_valid(d64_addr_v),
      .i_start_tx(d64_start), .i_cs(d64_cs),
      .i_rx_data(d64_rx_data), .i_rx_valid(d64_rx_valid), .o_rx_ready(d64_rx_ready),
      .o_tx_data(d64_tx_data), .o_tx_valid(d64_tx_valid), .i_tx_ready(d64_tx_ready),
      .o_wr_err(d64_wr_err), .o_rd_err(d64_rd_err), .i_err_clr(d64_err_clr));

   spi_slave_axi_bridge #(.AXI_DATA_WIDTH(128)) dut128 (
      .axi_aclk(axi_aclk), .axi_aresetn(axi_aresetn), .m_axi(axi128.master),
      .i_rxtx_addr(d128_addr), .i_rxtx_addr_valid(d128_addr_v),
      .i_start_tx(d128_start), .i_cs(d128_cs),
      .i_rx_data(d128_rx_data), .i_rx_valid(d128_rx_valid), .o_rx_ready(d128_rx_ready),
      .o_tx_data(d128_tx_data), .o_tx_valid(d128_tx_valid), .i_tx_ready(d128_tx_ready),
      .o_wr_err(d128_wr_err), .o_rd_err(d128_rd_err), .i_err_clr(d128_err_clr));

   typedef struct {
      bit          load;      // pulse rxtx_addr_valid before the write
      logic [31:0] addr;
      logic [31:0] word;
      int          aw_dly;    // cycles before aw_ready rises
      int          w_dly;     // cycles before w_ready rises
      logic [1:0]  bresp;
      bit          clr_b;     // err_clr in the B handshake cycle
      bit          ldb;       // rxtx_addr_valid in the B handshake cycle
      logic [31:0] ldb_addr;
      logic [31:0] exp_addr;
      logic [7:0]  exp_strb;
      logic [63:0] exp_data;
      bit          exp_err;
   } wvec_t;

   wvec_t vecs[8];

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge axi_aclk);
      #1;
   endtask

   // Acts as AXI slave for one write on the 64-bit instance.
   task automatic write64(input wvec_t v, output logic [31:0] aw_addr, output logic [7:0] strb,
                          output logic [63:0] wdata, output int aw_n, output int w_n,
                          output int b_n, output bit lat_ok, output bit fields_ok);
      int cyc;
      aw_n = 0; w_n = 0; b_n = 0; fields_ok = 1'b1;
      aw_addr = '0; strb = '0; wdata = '0;
      d64_rx_data  = v.word;
      d64_rx_valid = 1'b1;
      cyc = 0;
      while (!d64_rx_ready && cyc < 20) begin tick(); cyc++; end
      tick();
      d64_rx_valid = 1'b0;
      lat_ok = axi64.aw_valid && axi64.w_valid;
      cyc = 0;
      while (!axi64.b_ready && cyc < 30) begin
         axi64.aw_ready = (cyc >= v.aw_dly);
         axi64.w_ready  = (cyc >= v.w_dly);
         if (axi64.aw_valid && axi64.aw_ready) begin
            aw_n++;
            aw_addr = axi64.aw_addr;
            if (axi64.aw_len != 8'd0 || axi64.aw_size != 3'b010 ||
                axi64.aw_burst != 2'b01 || axi64.aw_id != 3'd1) fields_ok = 1'b0;
         end
         if (axi64.w_valid && axi64.w_ready) begin
            w_n++;
            strb  = axi64.w_strb;
            wdata = axi64.w_data;
            if (!axi64.w_last) fields_ok = 1'b0;
         end
         tick();
         cyc++;
      end
      axi64.aw_ready = 1'b0;
      axi64.w_ready  = 1'b0;
      axi64.b_valid  = 1'b1;
      axi64.b_resp   = v.bresp;
      d64_err_clr    = v.clr_b;
      d64_addr       = v.ldb_addr;
      d64_addr_v     = v.ldb;
      if (axi64.b_ready) b_n++;
      tick();
      axi64.b_valid = 1'b0;
      d64_err_clr   = 1'b0;
      d64_addr_v    = 1'b0;
      if (axi64.b_ready) b_n++;   // a second acceptance would be a fault
   endtask

   logic [31:0]  t_addr;
   logic [7:0]   t_strb;
   logic [63:0]  t_data;
   int           t_aw, t_w, t_b, ntx;
   bit           t_lat, t_fld, drain_ok, quiet_ok;
   logic [31:0]  txw[4];
   logic [127:0] beat_d, beat_e;

   initial begin
      #300000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      vecs[0] = '{1'b1, 32'h1000_0004, 32'hDEADBEEF, 0, 0, 2'b00, 1'b0, 1'b0, 32'h0,
                  32'h1000_0004, 8'hF0, 64'hDEADBEEF_DEADBEEF, 1'b0};
      vecs[1] = '{1'b0, 32'h0, 32'h1234_5678, 3, 0, 2'b00, 1'b0, 1'b0, 32'h0,
                  32'h1000_0008, 8'h0F, 64'h12345678_12345678, 1'b0};
      vecs[2] = '{1'b0, 32'h0, 32'hCAFE_F00D, 0, 2, 2'b10, 1'b0, 1'b0, 32'h0,
                  32'h1000_000C, 8'hF0, 64'hCAFEF00D_CAFEF00D, 1'b1};
      vecs[3] = '{1'b1, 32'hFFFF_FFFC, 32'hA5A5_A5A5, 1, 1, 2'b00, 1'b0, 1'b0, 32'h0,
                  32'hFFFF_FFFC, 8'hF0, 64'hA5A5A5A5_A5A5A5A5, 1'b1};
      vecs[4] = '{1'b0, 32'h0, 32'h0F0F_0F0F, 0, 0, 2'b00, 1'b0, 1'b0, 32'h0,
                  32'h0000_0000, 8'h0F, 64'h0F0F0F0F_0F0F0F0F, 1'b1};
      vecs[5] = '{1'b0, 32'h0, 32'h1111_1111, 0, 0, 2'b10, 1'b1, 1'b0, 32'h0,
                  32'h0000_0004, 8'hF0, 64'h11111111_11111111, 1'b1};
      vecs[6] = '{1'b0, 32'h0, 32'h2222_2222, 2, 2, 2'b00, 1'b0, 1'b1, 32'h0000_3000,
                  32'h0000_0008, 8'h0F, 64'h22222222_22222222, 1'b1};
      vecs[7] = '{1'b0, 32'h0, 32'h3333_3333, 0, 0, 2'b00, 1'b0, 1'b0, 32'h0,
                  32'h0000_3000, 8'h0F, 64'h33333333_33333333, 1'b1};

      axi_aresetn = 1'b0;
      d64_addr = '0;  d64_addr_v = 0;  d64_start = 0;  d64_cs = 1;  d64_rx_data = '0;
      d64_rx_valid = 0;  d64_tx_ready = 0;  d64_err_clr = 0;
      d128_addr = '0; d128_addr_v = 0; d128_start = 0; d128_cs = 1; d128_rx_data = '0;
      d128_rx_valid = 0; d128_tx_ready = 0; d128_err_clr = 0;
      axi64.aw_ready = 0; axi64.w_ready = 0; axi64.b_valid = 0; axi64.b_resp = 0;
      axi64.b_id = 0; axi64.b_user = 0; axi64.ar_ready = 0; axi64.r_valid = 0;
      axi64.r_data = 0; axi64.r_resp = 0; axi64.r_last = 0; axi64.r_id = 0; axi64.r_user = 0;
      axi128.aw_ready = 0; axi128.w_ready = 0; axi128.b_valid = 0; axi128.b_resp = 0;
      axi128.b_id = 0; axi128.b_user = 0; axi128.ar_ready = 0; axi128.r_valid = 0;
      axi128.r_data = 0; axi128.r_resp = 0; axi128.r_last = 1; axi128.r_id = 0; axi128.r_user = 0;

      repeat (3) tick();
      check("reset64 valid/ready/err", {d64_rx_ready, axi64.aw_valid, axi64.w_valid, axi64.b_ready,
            axi64.ar_valid, axi64.r_ready, d64_tx_valid, d64_wr_err, d64_rd_err}, 9'd0);
      check("reset64 addr", {axi64.aw_addr, axi64.ar_addr}, 64'd0);
      check("reset128 valid/ready/err", {d128_rx_ready, axi128.ar_valid, axi128.r_ready,
            d128_tx_valid, d128_rd_err}, 5'd0);
      axi_aresetn = 1'b1;
      tick(); tick();
      check("rx_ready after reset", d64_rx_ready, 1'b1);

      // ------------------------------------------------ table-driven writes
      for (int i = 0; i < 8; i++) begin
         if (vecs[i].load) begin
            d64_addr = vecs[i].addr; d64_addr_v = 1'b1;
            tick();
            d64_addr_v = 1'b0;
         end
         write64(vecs[i], t_addr, t_strb, t_data, t_aw, t_w, t_b, t_lat, t_fld);
         check($sformatf("v%0d aw_addr", i), t_addr, vecs[i].exp_addr);
         check($sformatf("v%0d w_strb", i), t_strb, vecs[i].exp_strb);
         check($sformatf("v%0d w_data", i), t_data, vecs[i].exp_data);
         check($sformatf("v%0d aw handshakes", i), t_aw, 1);
         check($sformatf("v%0d w handshakes", i), t_w, 1);
         check($sformatf("v%0d b accepts", i), t_b, 1);
         check($sformatf("v%0d aw+w latency", i), t_lat, 1'b1);
         check($sformatf("v%0d aw/w fields", i), t_fld, 1'b1);
         check($sformatf("v%0d wr_err", i), d64_wr_err, vecs[i].exp_err);
      end

      d64_err_clr = 1'b1;
      tick();
      d64_err_clr = 1'b0;
      check("wr_err after err_clr alone", d64_wr_err, 1'b0);

      // ------------------------------------------------ 128-bit read stream
      beat_d = {32'h4444_3333, 32'h3333_2222, 32'h2222_1111, 32'h1111_0000};
      beat_e = {32'hEEEE_0003, 32'hEEEE_0002, 32'hEEEE_0001, 32'hEEEE_0000};
      d128_cs = 1'b0;
      d128_addr = 32'h0000_2008; d128_addr_v = 1'b1;
      tick();
      d128_addr_v = 1'b0;
      d128_start = 1'b1;
      tick();
      d128_start = 1'b0;
      check("ar_valid after start", axi128.ar_valid, 1'b1);
      check("ar_addr aligned", axi128.ar_addr, 32'h0000_2000);
      check("ar size/len", {axi128.ar_size, axi128.ar_len}, {3'd4, 8'd0});
      axi128.ar_ready = 1'b1;
      tick();
      axi128.ar_ready = 1'b0;
      check("r_ready in data phase", {axi128.ar_valid, axi128.r_ready}, 2'b01);
      axi128.r_valid = 1'b1; axi128.r_data = beat_d; axi128.r_resp = 2'b00;
      tick();
      axi128.r_valid = 1'b0;
      check("tx_valid 1 cycle after r", d128_tx_valid, 1'b1);
      d128_tx_ready = 1'b1;
      ntx = 0;
      for (int c = 0; c < 10 && !axi128.ar_valid; c++) begin
         if (d128_tx_valid && ntx < 4) begin txw[ntx] = d128_tx_data; ntx++; end
         tick();
      end
      d128_tx_ready = 1'b0;
      check("tx word count", ntx, 2);
      check("tx word 0", txw[0], 32'h3333_2222);
      check("tx word 1", txw[1], 32'h4444_3333);
      check("next ar_addr", {axi128.ar_valid, axi128.ar_addr}, {1'b1, 32'h0000_2010});
      check("rd_err clean", d128_rd_err, 1'b0);

      // cs rises in R_DATA, beat arrives 2 cycles later and is drained
      axi128.ar_ready = 1'b1;
      tick();
      axi128.ar_ready = 1'b0;
      d128_cs = 1'b1;
      drain_ok = 1'b1;
      for (int k = 0; k < 2; k++) begin
         if (!axi128.r_ready || d128_tx_valid) drain_ok = 1'b0;
         tick();
      end
      if (!axi128.r_ready || d128_tx_valid) drain_ok = 1'b0;
      axi128.r_valid = 1'b1; axi128.r_data = beat_e;
      tick();
      axi128.r_valid = 1'b0;
      quiet_ok = 1'b1;
      for (int k = 0; k < 4; k++) begin
         if (d128_tx_valid || axi128.ar_valid || axi128.r_ready) quiet_ok = 1'b0;
         tick();
      end
      check("drain holds r_ready, no tx", drain_ok, 1'b1);
      check("idle after drain", quiet_ok, 1'b1);

      // restart rereads the same word; SLVERR sets rd_err
      d128_cs = 1'b0; d128_start = 1'b1;
      tick();
      d128_start = 1'b0;
      check("reread ar_addr", {axi128.ar_valid, axi128.ar_addr}, {1'b1, 32'h0000_2010});
      axi128.ar_ready = 1'b1;
      tick();
      axi128.ar_ready = 1'b0;
      axi128.r_valid = 1'b1; axi128.r_data = beat_e; axi128.r_resp = 2'b10;
      tick();
      axi128.r_valid = 1'b0; axi128.r_resp = 2'b00;
      check("rd_err on SLVERR", d128_rd_err, 1'b1);
      check("tx lane 0 after reread", {d128_tx_valid, d128_tx_data}, {1'b1, 32'hEEEE_0000});
      d128_tx_ready = 1'b1;
      tick();
      d128_cs = 1'b1;
      #1;
      check("no tx_valid once cs high", d128_tx_valid, 1'b0);
      tick();
      d128_tx_ready = 1'b0;
      d128_cs = 1'b0; d128_start = 1'b1;
      tick();
      d128_start = 1'b0;
      check("resume ar_addr", axi128.ar_addr, 32'h0000_2010);
      axi128.ar_ready = 1'b1;
      tick();
      axi128.ar_ready = 1'b0;
      axi128.r_valid = 1'b1; axi128.r_data = beat_e;
      tick();
      axi128.r_valid = 1'b0;
      check("resume at unsent lane 1", {d128_tx_valid, d128_tx_data}, {1'b1, 32'hEEEE_0001});
      d128_err_clr = 1'b1;
      tick();
      d128_err_clr = 1'b0;
      check("rd_err after err_clr", d128_rd_err, 1'b0);
      d128_cs = 1'b1;
      repeat (3) tick();

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end
endmodule
`default_nettype wire
